apb_master_ctrl: RTL and testbench

- Synthesizable, parametrised APB4 requester that replaces the hand-driven CPU write/read tasks with a valid/ready command and response interface.
- Generalises width through ADDR_W and DATA_W, and adds PSTRB, a PREADY wait-state timeout with abort, and back-pressured responses.
- Sits between an on-chip command source (sequencer or debug bridge) and the APB peripheral bus.
- Handles one outstanding transfer at a time.

---
 rtl/apb_master_pkg.sv | 27 ++
 rtl/apb_wait_timer.sv | 42 ++++
 rtl/apb_master_ctrl.sv | 152 +++++++++++++++
 tb/tb_apb_master_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types for the APB4 requester: FSM state encoding, response record
// and the sizing rule for the PREADY wait counter.
package apb_master_pkg;

   localparam int unsigned RSP_DATA_MAX_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_mst_state_t;

   // rdata is sized for the widest bus; narrower instances use the low bits.
   typedef struct packed {
      logic [RSP_DATA_MAX_W-1:0] rdata;
      logic                      slverr;
      logic                      timeout;
   } apb_rsp_t;

   // Counter must reach TIMEOUT_CYCLES-1; a disabled timeout still needs one bit.
   function automatic int unsigned wait_cnt_w(input int unsigned timeout_cycles);
      if (timeout_cycles == 0) return 1;
      return $unsigned($clog2(timeout_cycles + 1));
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent with PREADY low; flags the cycle on which the
// transfer must be aborted. Saturates instead of wrapping.
module apb_wait_timer
   import apb_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = wait_cnt_w(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Compared before the increment: abort lands on the TIMEOUT_CYCLES-th wait cycle.
   assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 requester driven by a valid/ready command port, returning results on a
// valid/ready response port; one transfer in flight at a time.
//
// Handshakes: a command transfers on a clock edge where req_valid && req_ready;
// a response transfers on an edge where rsp_valid && rsp_ready. The requester
// holds rsp_* stable until that edge; the source must hold req_* stable while
// req_valid is high and req_ready is low.
module apb_master_ctrl
   import apb_master_pkg::*;
#(
   parameter  int unsigned ADDR_W         = 8,
   parameter  int unsigned DATA_W         = 8,
   parameter  int unsigned TIMEOUT_CYCLES = 16,
   localparam int unsigned STRB_W         = DATA_W / 8
) (
   input  logic              cpu_pclk,
   input  logic              cpu_presetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_strb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              cpu_psel,
   output logic              cpu_penable,
   output logic              cpu_pwrite,
   output logic [ADDR_W-1:0] cpu_paddr,
   output logic [DATA_W-1:0] cpu_pwdata,
   output logic [STRB_W-1:0] cpu_pstrb,
   input  logic              cpu_pready,
   input  logic              cpu_pslverr,
   input  logic [DATA_W-1:0] cpu_prdata
);

   apb_mst_state_t    state_q;
   apb_rsp_t          rsp_q;
   logic              rsp_valid_q;
   logic              busy_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [STRB_W-1:0] pstrb_q;

   logic tmr_clr;
   logic tmr_en;
   logic tmr_expired;

   assign tmr_clr = (state_q == SETUP);
   assign tmr_en  = (state_q == ACCESS) && !cpu_pready;

   apb_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk    (cpu_pclk),
      .rst_n  (cpu_presetn),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expired(tmr_expired)
   );

   always_ff @(posedge cpu_pclk or negedge cpu_presetn) begin
      if (!cpu_presetn) begin
         state_q     <= IDLE;
         rsp_q       <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  paddr_q  <= req_addr;
                  pwrite_q <= req_write;
                  pwdata_q <= req_wdata;
                  pstrb_q  <= req_write ? req_strb : '0;
                  psel_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               // PREADY wins over the timeout when both land on the same edge.
               if (cpu_pready || tmr_expired) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  pwrite_q    <= 1'b0;
                  pwdata_q    <= '0;
                  pstrb_q     <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
                  if (cpu_pready) begin
                     rsp_q.slverr  <= cpu_pslverr;
                     rsp_q.timeout <= 1'b0;
                     rsp_q.rdata   <= (!pwrite_q && !cpu_pslverr) ?
                                      RSP_DATA_MAX_W'(cpu_prdata) : '0;
                  end else begin
                     rsp_q.slverr  <= 1'b1;
                     rsp_q.timeout <= 1'b1;
                     rsp_q.rdata   <= '0;
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q   <= 1'b0;
                  rsp_q.slverr  <= 1'b0;
                  rsp_q.timeout <= 1'b0;
                  busy_q        <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Gated by reset so no command is advertised while the block is held.
   assign req_ready   = cpu_presetn && (state_q == IDLE);

   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
   assign rsp_slverr  = rsp_q.slverr;
   assign rsp_timeout = rsp_q.timeout;
   assign busy        = busy_q;
   assign cpu_psel    = psel_q;
   assign cpu_penable = penable_q;
   assign cpu_pwrite  = pwrite_q;
   assign cpu_paddr   = paddr_q;
   assign cpu_pwdata  = pwdata_q;
   assign cpu_pstrb   = pstrb_q;

   logic unused_rsp_rdata;
   assign unused_rsp_rdata = ^rsp_q.rdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: a 32-bit instance with a 4-cycle timeout behind a
// memory-backed APB completer, and an 8-bit instance with the timeout disabled.
module tb_apb_master_ctrl;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 4;
   localparam int RW = DW + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // 32-bit instance
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [SW-1:0] req_strb  = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr, rsp_timeout, busy;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic          pready  = 1'b0;
   logic          pslverr = 1'b0;
   logic [DW-1:0] prdata  = '0;

   // 8-bit instance, timeout disabled
   logic       b_req_valid = 1'b0;
   logic       b_req_ready;
   logic       b_req_write = 1'b0;
   logic [7:0] b_req_addr  = '0;
   logic [7:0] b_req_wdata = '0;
   logic [0:0] b_req_strb  = '0;
   logic       b_rsp_valid;
   logic       b_rsp_ready = 1'b0;
   logic [7:0] b_rsp_rdata;
   logic       b_rsp_slverr, b_rsp_timeout, b_busy;
   logic       b_psel, b_penable, b_pwrite;
   logic [7:0] b_paddr;
   logic [7:0] b_pwdata;
   logic [0:0] b_pstrb;
   logic       b_pready  = 1'b0;
   logic       b_pslverr = 1'b0;
   logic [7:0] b_prdata  = '0;

   apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .cpu_pclk(clk), .cpu_presetn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .busy(busy),
      .cpu_psel(psel), .cpu_penable(penable), .cpu_pwrite(pwrite),
      .cpu_paddr(paddr), .cpu_pwdata(pwdata), .cpu_pstrb(pstrb),
      .cpu_pready(pready), .cpu_pslverr(pslverr), .cpu_prdata(prdata)
   );

   apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(0)) dut_b (
      .cpu_pclk(clk), .cpu_presetn(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_strb(b_req_strb),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_slverr(b_rsp_slverr), .rsp_timeout(b_rsp_timeout), .busy(b_busy),
      .cpu_psel(b_psel), .cpu_penable(b_penable), .cpu_pwrite(b_pwrite),
      .cpu_paddr(b_paddr), .cpu_pwdata(b_pwdata), .cpu_pstrb(b_pstrb),
      .cpu_pready(b_pready), .cpu_pslverr(b_pslverr), .cpu_prdata(b_prdata)
   );

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] slv_mem[256];
   logic [DW-1:0] ref_mem[256];
   int            cfg_waits = 0;
   logic          cfg_err   = 1'b0;
   int            acc_cnt   = 0;
   logic [AW-1:0] snap_addr;
   logic          snap_wr;
   logic [DW-1:0] snap_wdata;
   logic [SW-1:0] snap_strb;

   // Completer: cfg_waits wait states, then PREADY (with PSLVERR if cfg_err).
   // Outside ACCESS it drives noise on PREADY/PSLVERR, which must be ignored.
   always @(negedge clk) begin
      if (psel && penable) begin
         if (acc_cnt == 0) begin
            snap_addr = paddr; snap_wr = pwrite; snap_wdata = pwdata; snap_strb = pstrb;
         end else begin
            checks++;
            if ({paddr, pwrite, pwdata, pstrb} !== {snap_addr, snap_wr, snap_wdata, snap_strb}) begin
               failures++;
               $display("FAIL apb_stable: got addr=%h wr=%b wdata=%h strb=%h, required addr=%h wr=%b wdata=%h strb=%h",
                        paddr, pwrite, pwdata, pstrb, snap_addr, snap_wr, snap_wdata, snap_strb);
            end
         end
         if (!pwrite) begin
            checks++;
            if (pstrb !== '0) begin
               failures++;
               $display("FAIL read_pstrb: got %h required 0", pstrb);
            end
         end
         pready  = (acc_cnt == cfg_waits);
         pslverr = pready && cfg_err;
         prdata  = slv_mem[paddr];
         if (pready && !cfg_err && pwrite) begin
            for (int b = 0; b < SW; b++)
               if (pstrb[b]) slv_mem[paddr][8*b +: 8] = pwdata[8*b +: 8];
         end
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         pready  = 1'($urandom_range(0, 1));
         pslverr = 1'($urandom_range(0, 1));
         prdata  = $urandom;
      end
   end

   logic [DW-1:0] o_rdata;
   logic          o_slverr, o_timeout, o_psel_end, o_pen_end;
   int            o_lat, o_psel_edge, o_pen_edge;
   bit            o_ok;

   // One transfer on the 32-bit instance. Edges are numbered from the
   // acceptance edge (= 1); o_lat is the edge on which rsp_valid appears.
   task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] st, input int waits, input logic err, input int hold);
      int n;
      o_ok = 1'b1;
      @(negedge clk);
      cfg_waits = waits; cfg_err = err;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = st;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) begin req_valid = 1'b0; o_ok = 1'b0; return; end
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = $urandom;
      o_lat = 1;
      o_psel_edge = psel ? 1 : 0;
      o_pen_edge  = penable ? 1 : 0;
      while (!rsp_valid && o_lat < 200) begin
         @(posedge clk); #1;
         o_lat++;
         if (psel && o_psel_edge == 0) o_psel_edge = o_lat;
         if (penable && o_pen_edge == 0) o_pen_edge = o_lat;
      end
      if (!rsp_valid) begin o_ok = 1'b0; return; end
      o_rdata = rsp_rdata; o_slverr = rsp_slverr; o_timeout = rsp_timeout;
      o_psel_end = psel; o_pen_end = penable;
      repeat (hold) @(negedge clk);
      @(negedge clk); rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #10;
      checks++;
      if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
         failures++; $display("FAIL reset_apb: got %h required 0", {psel, penable, pwrite, paddr, pwdata, pstrb});
      end
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy} !== '0) begin
         failures++; $display("FAIL reset_rsp: got %h required 0", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy});
      end
      checks++;
      if ({req_ready, b_req_ready} !== 2'b00) begin
         failures++; $display("FAIL reset_req_ready: got %b required 00", {req_ready, b_req_ready});
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ready, busy, b_req_ready, b_busy} !== 4'b1010) begin
         failures++; $display("FAIL post_reset_idle: got %b required 1010", {req_ready, busy, b_req_ready, b_busy});
      end
   endtask

   task automatic test_write_zero_wait();
      @(negedge clk);
      b_pready = 1'b1; b_pslverr = 1'b0;
      b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 8'h10; b_req_wdata = 8'hA5; b_req_strb = 1'b1;
      @(posedge clk); #1; b_req_valid = 1'b0;
      checks++;
      if ({b_psel, b_penable} !== 2'b10) begin
         failures++; $display("FAIL zw_edge1 psel/penable: got %b required 10", {b_psel, b_penable});
      end
      @(posedge clk); #1;
      checks++;
      if ({b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pstrb} !== {3'b111, 8'h10, 8'hA5, 1'b1}) begin
         failures++; $display("FAIL zw_access: got %h required %h",
                              {b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pstrb}, {3'b111, 8'h10, 8'hA5, 1'b1});
      end
      @(posedge clk); #1;
      checks++;
      if ({b_rsp_valid, b_rsp_slverr, b_rsp_timeout, b_rsp_rdata, b_psel, b_penable} !== {3'b100, 8'h00, 2'b00}) begin
         failures++; $display("FAIL zw_rsp_edge3: got %h required %h",
                              {b_rsp_valid, b_rsp_slverr, b_rsp_timeout, b_rsp_rdata, b_psel, b_penable}, {3'b100, 8'h00, 2'b00});
      end
      @(negedge clk); b_rsp_ready = 1'b1;
      @(posedge clk); #1; b_rsp_ready = 1'b0;
      checks++;
      if ({b_rsp_valid, b_busy, b_req_ready} !== 3'b001) begin
         failures++; $display("FAIL zw_consume: got %b required 001", {b_rsp_valid, b_busy, b_req_ready});
      end
   endtask

   task automatic test_no_timeout();
      @(negedge clk);
      b_pready = 1'b0; b_prdata = 8'h3C;
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'h33;
      @(posedge clk); #1; b_req_valid = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checks++;
      if ({b_psel, b_penable, b_busy, b_rsp_valid, b_rsp_timeout} !== 5'b11100) begin
         failures++; $display("FAIL no_timeout_wait: got %b required 11100", {b_psel, b_penable, b_busy, b_rsp_valid, b_rsp_timeout});
      end
      @(negedge clk); b_pready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({b_rsp_valid, b_rsp_slverr, b_rsp_timeout, b_rsp_rdata} !== {3'b100, 8'h3C}) begin
         failures++; $display("FAIL no_timeout_done: got %h required %h", {b_rsp_valid, b_rsp_slverr, b_rsp_timeout, b_rsp_rdata}, {3'b100, 8'h3C});
      end
      @(negedge clk); b_pready = 1'b0; b_rsp_ready = 1'b1;
      @(posedge clk); #1; b_rsp_ready = 1'b0;
      checks++;
      if (b_rsp_valid !== 1'b0) begin
         failures++; $display("FAIL no_timeout_consume: got %b required 0", b_rsp_valid);
      end
   endtask

   task automatic test_read_wait_states();
      slv_mem[8'h04] = 32'hDEADBEEF; ref_mem[8'h04] = 32'hDEADBEEF;
      do_xfer(1'b0, 8'h04, '0, 4'hF, 3, 1'b0, 0);
      checks++;
      if (!o_ok) begin failures++; $display("FAIL rd_wait_handshake: got stalled required completion"); end
      checks++;
      if ({o_rdata, o_slverr, o_timeout} !== {32'hDEADBEEF, 2'b00}) begin
         failures++; $display("FAIL rd_wait_rsp: got %h required %h", {o_rdata, o_slverr, o_timeout}, {32'hDEADBEEF, 2'b00});
      end
      checks++;
      if (o_lat != 6 || o_psel_edge != 1 || o_pen_edge != 2) begin
         failures++; $display("FAIL rd_wait_timing: got rsp@%0d psel@%0d pen@%0d required 6/1/2", o_lat, o_psel_edge, o_pen_edge);
      end
   endtask

   task automatic test_slave_error();
      slv_mem[8'h30] = 32'h55; ref_mem[8'h30] = 32'h55;
      do_xfer(1'b0, 8'h30, '0, 4'h0, 1, 1'b1, 0);
      checks++;
      if (!o_ok || {o_rdata, o_slverr, o_timeout} !== {32'h0, 2'b10}) begin
         failures++; $display("FAIL slverr_rsp: got ok=%0b %h required %h", o_ok, {o_rdata, o_slverr, o_timeout}, {32'h0, 2'b10});
      end
      checks++;
      if (o_lat != 4) begin failures++; $display("FAIL slverr_latency: got %0d required 4", o_lat); end
   endtask

   task automatic test_timeout();
      do_xfer(1'b1, 8'h40, 32'h12345678, 4'hF, 50, 1'b0, 0);
      checks++;
      if (!o_ok || {o_rdata, o_slverr, o_timeout} !== {32'h0, 2'b11}) begin
         failures++; $display("FAIL timeout_rsp: got ok=%0b %h required %h", o_ok, {o_rdata, o_slverr, o_timeout}, {32'h0, 2'b11});
      end
      checks++;
      if (o_lat != 2 + TO || {o_psel_end, o_pen_end} !== 2'b00) begin
         failures++; $display("FAIL timeout_abort: got rsp@%0d psel/pen=%b required rsp@%0d 00", o_lat, {o_psel_end, o_pen_end}, 2 + TO);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] wd2;
      logic [SW-1:0] st2;
      logic [RW-1:0] held;
      int n;
      wd2 = $urandom; st2 = 4'($urandom_range(1, 15));
      cfg_waits = 0; cfg_err = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h50; req_wdata = 32'h11223344; req_strb = 4'hF;
      @(posedge clk); #1; req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (!rsp_valid) begin failures++; $display("FAIL b2b_first_rsp: got no rsp_valid required 1"); end
      held = {rsp_timeout, rsp_slverr, rsp_rdata};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h51; req_wdata = wd2; req_strb = st2;
         end
         checks++;
         if ({rsp_valid, rsp_timeout, rsp_slverr, rsp_rdata} !== {1'b1, RW'(0)} ||
             {req_ready, psel} !== 2'b00) begin
            failures++; $display("FAIL b2b_hold cycle %0d: got rsp=%h req_ready=%b psel=%b required rsp=%h 0 0",
                                 i, {rsp_valid, rsp_timeout, rsp_slverr, rsp_rdata}, req_ready, psel, {1'b1, held});
         end
      end
      @(negedge clk); rsp_ready = 1'b1;
      checks++;
      if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_during_consume: got %b required 0", req_ready); end
      @(posedge clk); #1; rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, req_ready, psel} !== 3'b010) begin
         failures++; $display("FAIL b2b_idle_gap: got %b required 010", {rsp_valid, req_ready, psel});
      end
      @(posedge clk); #1; req_valid = 1'b0;
      checks++;
      if ({psel, penable, paddr, pwdata} !== {2'b10, 8'h51, wd2}) begin
         failures++; $display("FAIL b2b_second_psel: got %h required %h", {psel, penable, paddr, pwdata}, {2'b10, 8'h51, wd2});
      end
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      @(negedge clk); rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
      ref_mem[8'h50] = 32'h11223344;
      for (int b = 0; b < SW; b++) if (st2[b]) ref_mem[8'h51][8*b +: 8] = wd2[8*b +: 8];
      do_xfer(1'b0, 8'h51, '0, 4'h0, 0, 1'b0, 0);
      checks++;
      if (!o_ok || o_rdata !== ref_mem[8'h51]) begin
         failures++; $display("FAIL b2b_readback: got ok=%0b %h required %h", o_ok, o_rdata, ref_mem[8'h51]);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [DW-1:0] wd;
      int n;
      cfg_waits = 3; cfg_err = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h60;
      @(posedge clk); #1; req_valid = 1'b0;
      n = 0;
      while (!penable && n < 10) begin @(posedge clk); #1; n++; end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({psel, penable, busy, rsp_valid, req_ready} !== 5'b00000) begin
         failures++; $display("FAIL reset_mid_access: got %b required 00000", {psel, penable, busy, rsp_valid, req_ready});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rsp_valid, busy, psel} !== 3'b000) begin
         failures++; $display("FAIL reset_no_rsp: got %b required 000", {rsp_valid, busy, psel});
      end
      wd = $urandom;
      do_xfer(1'b1, 8'h20, wd, 4'hF, 1, 1'b0, 0);
      checks++;
      if (!o_ok || {o_slverr, o_timeout} !== 2'b00 || o_lat != 4) begin
         failures++; $display("FAIL reset_recover_write: got ok=%0b err/to=%b lat=%0d required 1 00 4", o_ok, {o_slverr, o_timeout}, o_lat);
      end
      ref_mem[8'h20] = wd;
      do_xfer(1'b0, 8'h20, '0, 4'h0, 0, 1'b0, 0);
      checks++;
      if (!o_ok || o_rdata !== wd) begin
         failures++; $display("FAIL reset_recover_read: got ok=%0b %h required %h", o_ok, o_rdata, wd);
      end
   endtask

   task automatic test_random();
      logic [RW-1:0] exp_q[$];
      logic [RW-1:0] exp;
      logic          wr, err;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [SW-1:0] st;
      int            waits, hold, exp_lat;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1)); addr = AW'($urandom_range(0, 15));
         wd = $urandom; st = SW'($urandom_range(0, 15));
         waits = $urandom_range(0, 6); err = ($urandom_range(0, 7) == 0); hold = $urandom_range(0, 3);
         if (waits >= TO) begin
            exp = {2'b11, 32'h0}; exp_lat = 2 + TO;
         end else begin
            exp_lat = 3 + waits;
            if (err) exp = {2'b01, 32'h0};
            else if (wr) begin
               exp = {2'b00, 32'h0};
               for (int b = 0; b < SW; b++) if (st[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
            end else exp = {2'b00, ref_mem[addr]};
         end
         exp_q.push_back(exp);
         do_xfer(wr, addr, wd, st, waits, err, hold);
         exp = exp_q.pop_front();
         checks++;
         if (!o_ok || {o_timeout, o_slverr, o_rdata} !== exp) begin
            failures++; $display("FAIL rand_rsp #%0d: got ok=%0b %h required %h", i, o_ok, {o_timeout, o_slverr, o_rdata}, exp);
         end
         checks++;
         if (o_lat != exp_lat) begin
            failures++; $display("FAIL rand_latency #%0d: got %0d required %0d", i, o_lat, exp_lat);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         slv_mem[i] = $urandom;
         ref_mem[i] = slv_mem[i];
      end
      test_reset();
      test_write_zero_wait();
      test_no_timeout();
      test_read_wait_states();
      test_slave_error();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
